// File: rtl/hcheck_sink_pkg.sv
// Shared definitions for the hcheck message sink: default channel widths,
// FSM state encoding and the redundancy fold used by sources and sinks alike.
package hcheck_sink_pkg;

   localparam int NS_ADDRESS_SIZE = 6;
   localparam int NS_DATA_SIZE    = 4;
   localparam int NS_REDUN_SIZE   = 4;

   // Upper bounds for the generic fold; {src,dst,dat} and RSZ must fit.
   localparam int FOLD_MAX    = 64;
   localparam int REDUN_MAX   = 16;
   localparam int REDUN_IDX_W = $clog2(REDUN_MAX);

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_CHK  = 3'd2,
      ST_WAIT = 3'd3,
      ST_ACK  = 3'd4
   } state_t;

   // XOR-fold into rsz-bit chunks starting at the LSB, so a short top chunk
   // behaves as if zero-padded at its MSB end.
   function automatic logic [REDUN_MAX-1:0] redun(input logic [FOLD_MAX-1:0] bits,
                                                  input int rsz);
      logic [REDUN_MAX-1:0] acc;
      logic [FOLD_MAX-1:0]  rest;
      int                   pos;
      acc  = '0;
      rest = bits;
      pos  = 0;
      for (int i = 0; i < FOLD_MAX; i++) begin
         acc[REDUN_IDX_W'(pos)] ^= rest[0];
         rest = rest >> 1;
         pos  = (pos == rsz - 1) ? 0 : pos + 1;
      end
      return acc;
   endfunction

endpackage

// File: rtl/hcheck_sink_if.sv
// One message channel: address/data/redundancy fields plus a 2-phase req/ack pair.
interface hcheck_sink_if
   import hcheck_sink_pkg::*;
#(
   parameter int ASZ = NS_ADDRESS_SIZE,
   parameter int DSZ = NS_DATA_SIZE,
   parameter int RSZ = NS_REDUN_SIZE
);

   logic [ASZ-1:0] src;
   logic [ASZ-1:0] dst;
   logic [DSZ-1:0] dat;
   logic [RSZ-1:0] red;
   logic           req;
   logic           ack;

   modport master (output src, dst, dat, red, req, input ack);
   modport slave  (input src, dst, dat, red, req, output ack);

endinterface

// File: rtl/hcheck_sink_redun_chk.sv
// Combinational redundancy check: compares a received red field against the
// fold of {src,dst,dat}.
module hcheck_sink_redun_chk
   import hcheck_sink_pkg::*;
#(
   parameter int ASZ = NS_ADDRESS_SIZE,
   parameter int DSZ = NS_DATA_SIZE,
   parameter int RSZ = NS_REDUN_SIZE
) (
   input  logic [ASZ-1:0] src,
   input  logic [ASZ-1:0] dst,
   input  logic [DSZ-1:0] dat,
   input  logic [RSZ-1:0] red,
   output logic           red_ok
);

   logic [RSZ-1:0] red_calc;

   assign red_calc = RSZ'(redun(FOLD_MAX'({src, dst, dat}), RSZ));
   assign red_ok   = (red == red_calc);

endmodule

// File: rtl/hcheck_sink.sv
// Terminal message consumer: takes one message per 2-phase handshake, checks
// redundancy and destination, and keeps saturating good/bad counters.
module hcheck_sink
   import hcheck_sink_pkg::*;
#(
   parameter int          ASZ     = NS_ADDRESS_SIZE,
   parameter int          DSZ     = NS_DATA_SIZE,
   parameter int          RSZ     = NS_REDUN_SIZE,
   parameter int unsigned MY_ADDR = 0,
   parameter int unsigned ACK_DLY = 0,
   parameter int          CSZ     = 16
) (
   input  logic           gch_clk,
   input  logic           gch_reset,
   output logic           gch_ready,
   hcheck_sink_if.slave   rcv0,
   output logic [CSZ-1:0] cnt_ok,
   output logic [CSZ-1:0] cnt_err,
   output logic           err_flag,
   output logic [DSZ-1:0] last_dat
);

   state_t         state_q, state_d;
   logic [ASZ-1:0] src_hold, dst_hold;
   logic [DSZ-1:0] dat_hold;
   logic [RSZ-1:0] red_hold;
   logic [7:0]     dly_cnt;
   logic           req_smp;
   logic           ack_q;
   logic           pending;
   logic           red_ok;
   logic           good;

   assign rcv0.ack = ack_q;
   assign pending  = (rcv0.req != ack_q);
   assign good     = red_ok && (dst_hold == ASZ'(MY_ADDR));

   hcheck_sink_redun_chk #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_redun_chk (
      .src    (src_hold),
      .dst    (dst_hold),
      .dat    (dat_hold),
      .red    (red_hold),
      .red_ok (red_ok)
   );

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: if (pending) state_d = ST_CHK;
         ST_CHK:  state_d = (ACK_DLY > 0) ? ST_WAIT : ST_ACK;
         ST_WAIT: if (dly_cnt == 8'd1) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         state_q   <= ST_INIT;
         gch_ready <= 1'b0;
         ack_q     <= 1'b0;
         req_smp   <= 1'b0;
         // NOTE: holding regs are reset too; they are few and it keeps the checker input defined.
         src_hold  <= '0;
         dst_hold  <= '0;
         dat_hold  <= '0;
         red_hold  <= '0;
         dly_cnt   <= '0;
         cnt_ok    <= '0;
         cnt_err   <= '0;
         err_flag  <= 1'b0;
         last_dat  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_INIT: gch_ready <= 1'b1;
            ST_IDLE: if (pending) begin
               src_hold <= rcv0.src;
               dst_hold <= rcv0.dst;
               dat_hold <= rcv0.dat;
               red_hold <= rcv0.red;
               req_smp  <= rcv0.req;
            end
            ST_CHK: begin
               if (good) begin
                  if (cnt_ok != '1) cnt_ok <= cnt_ok + CSZ'(1);
                  last_dat <= dat_hold;
               end else begin
                  if (cnt_err != '1) cnt_err <= cnt_err + CSZ'(1);
                  err_flag <= 1'b1;
               end
               if (ACK_DLY > 0) dly_cnt <= 8'(ACK_DLY);
            end
            ST_WAIT: dly_cnt <= dly_cnt - 8'd1;
            // req_smp differs from ack_q here, so this is the single toggle.
            ST_ACK:  ack_q <= req_smp;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hcheck_sink.sv
// Self-checking bench for hcheck_sink: two instances (no ack delay, ack delay 4)
// driven with directed and random messages against a behavioural model.
module tb_hcheck_sink;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       ready0, ready4, flag0, flag4;
   logic [3:0] ok0, err0, ok4, err4, last0, last4;

   hcheck_sink_if #(.ASZ(6), .DSZ(4), .RSZ(4)) ch0 ();
   hcheck_sink_if #(.ASZ(6), .DSZ(4), .RSZ(4)) ch4 ();

   hcheck_sink #(.ASZ(6), .DSZ(4), .RSZ(4), .MY_ADDR(2), .ACK_DLY(0), .CSZ(4)) u_dut0 (
      .gch_clk(clk), .gch_reset(rst_n), .gch_ready(ready0), .rcv0(ch0.slave),
      .cnt_ok(ok0), .cnt_err(err0), .err_flag(flag0), .last_dat(last0)
   );

   hcheck_sink #(.ASZ(6), .DSZ(4), .RSZ(4), .MY_ADDR(2), .ACK_DLY(4), .CSZ(4)) u_dut4 (
      .gch_clk(clk), .gch_reset(rst_n), .gch_ready(ready4), .rcv0(ch4.slave),
      .cnt_ok(ok4), .cnt_err(err4), .err_flag(flag4), .last_dat(last4)
   );

   int         total = 0;
   int         bad   = 0;
   int         m_ok[2];
   int         m_err[2];
   logic       m_flag[2];
   logic [3:0] m_last[2];

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Fold of the 16-bit concatenation {src,dst,dat} into nibbles.
   function automatic logic [3:0] ref_red(input logic [5:0] s, input logic [5:0] d, input logic [3:0] t);
      int unsigned v;
      v = (int'(s) << 10) | (int'(d) << 4) | int'(t);
      return 4'((v ^ (v >> 4) ^ (v >> 8) ^ (v >> 12)) % 16);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ok[i] = 0; m_err[i] = 0; m_flag[i] = 1'b0; m_last[i] = 4'h0;
      end
   endtask

   task automatic model_apply(input int d, input logic [5:0] s, input logic [5:0] dd,
                              input logic [3:0] t, input logic [3:0] r);
      if (r == ref_red(s, dd, t) && dd == 6'd2) begin
         if (m_ok[d] < 15) m_ok[d]++;
         m_last[d] = t;
      end else begin
         if (m_err[d] < 15) m_err[d]++;
         m_flag[d] = 1'b1;
      end
   endtask

   task automatic drive(input int d, input logic [5:0] s, input logic [5:0] dd,
                        input logic [3:0] t, input logic [3:0] r);
      if (d == 0) begin
         ch0.src = s; ch0.dst = dd; ch0.dat = t; ch0.red = r; ch0.req = ~ch0.req;
      end else begin
         ch4.src = s; ch4.dst = dd; ch4.dat = t; ch4.red = r; ch4.req = ~ch4.req;
      end
   endtask

   function automatic logic ack_of(input int d);
      return (d == 0) ? ch0.ack : ch4.ack;
   endfunction

   task automatic check_outputs(input int d);
      logic [3:0] o_ok, o_err, o_last;
      logic       o_flag, o_ack, o_req;
      if (d == 0) begin
         o_ok = ok0; o_err = err0; o_last = last0; o_flag = flag0; o_ack = ch0.ack; o_req = ch0.req;
      end else begin
         o_ok = ok4; o_err = err4; o_last = last4; o_flag = flag4; o_ack = ch4.ack; o_req = ch4.req;
      end
      check($sformatf("dut%0d cnt_ok", d),   32'(o_ok),   32'(m_ok[d]));
      check($sformatf("dut%0d cnt_err", d),  32'(o_err),  32'(m_err[d]));
      check($sformatf("dut%0d err_flag", d), 32'(o_flag), 32'(m_flag[d]));
      check($sformatf("dut%0d last_dat", d), 32'(o_last), 32'(m_last[d]));
      check($sformatf("dut%0d ack==req", d), 32'(o_ack),  32'(o_req));
   endtask

   // Called #1 after a rising edge with the DUT idle; returns #1 after the ack edge.
   task automatic send(input int d, input logic [5:0] s, input logic [5:0] dd,
                       input logic [3:0] t, input logic [3:0] r);
      logic old_ack;
      int   n;
      old_ack = ack_of(d);
      drive(d, s, dd, t, r);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (ack_of(d) == old_ack && n < 40);
      check($sformatf("dut%0d latency", d), 32'(n), (d == 0) ? 32'd3 : 32'd7);
      model_apply(d, s, dd, t, r);
      check_outputs(d);
   endtask

   initial begin
      logic [5:0] s, dd;
      logic [3:0] t, r;
      logic       prev;
      int         toggles, first, n;

      model_reset();
      rst_n = 1'b0;
      drive(0, 6'd0, 6'd0, 4'd0, 4'd0);
      drive(1, 6'd0, 6'd0, 4'd0, 4'd0);
      ch0.req = 1'b0;
      ch4.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready0", 32'(ready0), 32'd0);
      check_outputs(0);
      check_outputs(1);

      // Ready rises on the first edge after release.
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("init ready0", 32'(ready0), 32'd0);
      check("init ready4", 32'(ready4), 32'd0);
      @(posedge clk); #1;
      check("run ready0", 32'(ready0), 32'd1);
      check("run ready4", 32'(ready4), 32'd1);

      // Directed messages on the undelayed sink.
      send(0, 6'd1, 6'd2, 4'd5, 4'd3);
      send(0, 6'd1, 6'd2, 4'd5, 4'd4);
      send(0, 6'd1, 6'd3, 4'd5, 4'd2);
      send(0, 6'd1, 6'd2, 4'd9, ref_red(6'd1, 6'd2, 4'd9));
      check("flag sticky", 32'(flag0), 32'd1);

      // Delayed sink: plain message, then a second req toggle while busy.
      send(1, 6'd1, 6'd2, 4'd5, 4'd3);
      prev = ch4.ack;
      drive(1, 6'd5, 6'd2, 4'd9, ref_red(6'd5, 6'd2, 4'd9));
      model_apply(1, 6'd5, 6'd2, 4'd9, ref_red(6'd5, 6'd2, 4'd9));
      repeat (2) begin @(posedge clk); #1; end
      drive(1, 6'd7, 6'd2, 4'd3, ~ref_red(6'd7, 6'd2, 4'd3));
      model_apply(1, 6'd7, 6'd2, 4'd3, ~ref_red(6'd7, 6'd2, 4'd3));
      toggles = 0; first = 0; n = 2;
      while (toggles < 2 && n < 80) begin
         @(posedge clk); #1; n++;
         if (ch4.ack !== prev) begin
            toggles++;
            prev = ch4.ack;
            if (toggles == 1) first = n;
         end
      end
      check("busy first latency", 32'(first), 32'd7);
      check("busy ack toggles", 32'(toggles), 32'd2);
      check_outputs(1);
      repeat (10) begin @(posedge clk); #1; end
      check_outputs(1);

      // Random traffic, mostly well-formed, on both sinks.
      for (int i = 0; i < 24; i++) begin
         s  = 6'($urandom_range(0, 63));
         t  = 4'($urandom_range(0, 15));
         dd = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd2;
         r  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ref_red(s, dd, t);
         send(i % 2, s, dd, t, r);
      end

      // Push the good counter of the undelayed sink past saturation.
      for (int i = 0; i < 17; i++) begin
         s = 6'($urandom_range(0, 63));
         t = 4'($urandom_range(0, 15));
         send(0, s, 6'd2, t, ref_red(s, 6'd2, t));
      end
      check("cnt_ok saturated", 32'(ok0), 32'hF);

      // Reset while the delayed sink sits in its ack delay.
      drive(1, 6'd3, 6'd2, 4'd6, ref_red(6'd3, 6'd2, 4'd6));
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midwait ready4", 32'(ready4), 32'd0);
      check("midwait ack4", 32'(ch4.ack), 32'd0);
      check("midwait ok4", 32'(ok4), 32'd0);
      check("midwait err4", 32'(err4), 32'd0);
      check("midwait flag4", 32'(flag4), 32'd0);
      check("midwait last4", 32'(last4), 32'd0);
      check("midwait ok0", 32'(ok0), 32'd0);
      ch0.req = 1'b0;
      ch4.req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rerun ready4", 32'(ready4), 32'd1);
      send(1, 6'd1, 6'd2, 4'd5, 4'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
